// File: rtl/sevenseg_scan_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph constants,
// scan phase enum and a glyph lookup helper.
package sevenseg_scan_pkg;

    // Active-high glyphs, bit order {a,b,c,d,e,f,g} (bit 6 = a).
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Per-digit slot phase: all anodes off, then the digit lit.
    typedef enum logic {
        SCAN_BLANK,
        SCAN_ON
    } scan_state_t;

    function automatic logic [6:0] seg_glyph(input logic [3:0] hex);
        logic [6:0] g;
        g = SEG_OFF;
        unique case (hex)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            4'hF: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sevenseg_scan_sevenseg.sv
// Hex nibble to active-high 7-segment glyph decoder.
module sevenseg
    import sevenseg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup, no state.
    always_comb begin
        seg = seg_glyph(hex);
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode 7-segment driver with shadow/active
// register sets so a displayed frame never tears.
module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_CYCLES = 100_000,
    parameter int unsigned BLANK_CYCLES   = 1_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int unsigned PHASE_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    scan_state_t          state, state_nx;
    logic [IDX_W-1:0]     idx, idx_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 boundary;

    logic [4*NUM_DIGITS-1:0] sh_digits, sh_digits_nx, ac_digits, ac_digits_nx;
    logic [NUM_DIGITS-1:0]   sh_blank,  sh_blank_nx,  ac_blank,  ac_blank_nx;
    logic [NUM_DIGITS-1:0]   sh_dp,     sh_dp_nx,     ac_dp,     ac_dp_nx;

    logic [3:0] nibble_nx;
    logic       blank_sel_nx;
    logic       dp_sel_nx;
    logic       lit_nx;
    logic [6:0] glyph_nx;

    // Phase/digit sequencing; boundary marks leaving the last digit's ON.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + 1'b1;
        boundary = 1'b0;
        unique case (state)
            SCAN_BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_nx = SCAN_ON;
                    cnt_nx   = '0;
                end
            end
            SCAN_ON: begin
                if (cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_nx = SCAN_BLANK;
                    cnt_nx   = '0;
                    if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_nx   = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
        endcase
    end

    // Shadow follows load; active copies the post-load shadow at the boundary,
    // so a load on the boundary edge lands directly in the active set.
    always_comb begin
        sh_digits_nx = load ? digits : sh_digits;
        sh_blank_nx  = load ? blank  : sh_blank;
        sh_dp_nx     = load ? dp     : sh_dp;
        ac_digits_nx = boundary ? sh_digits_nx : ac_digits;
        ac_blank_nx  = boundary ? sh_blank_nx  : ac_blank;
        ac_dp_nx     = boundary ? sh_dp_nx     : ac_dp;
    end

    // Select the next digit's active data so outputs register with the state.
    always_comb begin
        nibble_nx    = '0;
        blank_sel_nx = 1'b1;
        dp_sel_nx    = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == IDX_W'(i)) begin
                nibble_nx    = ac_digits_nx[4*i +: 4];
                blank_sel_nx = ac_blank_nx[i];
                dp_sel_nx    = ac_dp_nx[i];
            end
        end
        lit_nx = (state_nx == SCAN_ON) && !blank_sel_nx;
    end

    sevenseg u_dec (
        .hex (nibble_nx),
        .seg (glyph_nx)
    );

    // Register FSM, data sets and pin outputs on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN_BLANK;
            idx         <= '0;
            cnt         <= '0;
            sh_digits   <= '0;
            sh_blank    <= '1;
            sh_dp       <= '0;
            ac_digits   <= '0;
            ac_blank    <= '1;
            ac_dp       <= '0;
            an_n        <= '1;
            seg_n       <= '1;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            sh_digits   <= sh_digits_nx;
            sh_blank    <= sh_blank_nx;
            sh_dp       <= sh_dp_nx;
            ac_digits   <= ac_digits_nx;
            ac_blank    <= ac_blank_nx;
            ac_dp       <= ac_dp_nx;
            frame_start <= boundary;
            if (lit_nx) begin
                an_n  <= ~(NUM_DIGITS'(1) << idx_nx);
                seg_n <= ~glyph_nx;
                dp_n  <= ~dp_sel_nx;
            end else begin
                an_n  <= '1;
                seg_n <= '1;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: time-since-reset display model plus pinned values.
module tb_sevenseg_scan;

    localparam int unsigned N     = 4;
    localparam int unsigned R     = 4;
    localparam int unsigned B     = 2;
    localparam int unsigned SLOT  = B + R;
    localparam int unsigned FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   digits = '0;
    logic [3:0]    blank = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_start;

    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset and the two register sets.
    int unsigned t = 0;
    logic [15:0] m_sh_d, m_ac_d;
    logic [3:0]  m_sh_b, m_ac_b, m_sh_p, m_ac_p;
    logic [6:0]  glyph [16];

    sevenseg_scan #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .digits      (digits),
        .blank       (blank),
        .dp          (dp),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic cycle();
        int unsigned pos, dig, w;
        logic on;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_fs;
        logic [3:0] nib;
        @(posedge clk);
        #1;
        if (rst) begin
            t = 0;
            m_sh_d = '0; m_ac_d = '0;
            m_sh_b = '1; m_ac_b = '1;
            m_sh_p = '0; m_ac_p = '0;
        end else begin
            t++;
            if (load) begin
                m_sh_d = digits; m_sh_b = blank; m_sh_p = dp;
            end
            if (t % FRAME == 0) begin
                m_ac_d = m_sh_d; m_ac_b = m_sh_b; m_ac_p = m_sh_p;
            end
        end
        pos  = t % FRAME;
        dig  = pos / SLOT;
        w    = pos % SLOT;
        e_fs = (pos == 0) && (t != 0);
        on   = (w >= B) && !m_ac_b[dig];
        nib  = 4'((m_ac_d >> (4 * dig)) & 16'hF);
        e_an  = on ? ~(4'b0001 << dig) : 4'b1111;
        e_seg = on ? ~glyph[nib] : 7'b1111111;
        e_dp  = on ? ~m_ac_p[dig] : 1'b1;
        chk("an_n",        32'(an_n),        32'(e_an));
        chk("seg_n",       32'(seg_n),       32'(e_seg));
        chk("dp_n",        32'(dp_n),        32'(e_dp));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic do_reset();
        load = 1'b0;
        rst  = 1'b1;
        cycle();
        rst  = 1'b0;
    endtask

    initial begin
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101; glyph[3]  = 7'b1111001;
        glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011; glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000;
        glyph[8]  = 7'b1111111; glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
        glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;

        // Reset with no load: dark, frame_start only at 24 and 48.
        do_reset();
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_fs", 32'(frame_start), 32'h0);
        while (t < 50) begin
            cycle();
            chk("dark_an", 32'(an_n), 32'hF);
            chk("dark_seg", 32'(seg_n), 32'h7F);
            if (t == 24 || t == 48) chk("fs_pin", 32'(frame_start), 32'h1);
        end

        // Load 1234 at t=5, dp on digit 0.
        do_reset();
        while (t < 36) begin
            if (t == 4) begin load = 1'b1; digits = 16'h1234; blank = 4'b0000; dp = 4'b0001; end
            cycle();
            load = 1'b0;
            if (t == 20) chk("pre_frame_dark", 32'(an_n), 32'hF);
            if (t == 24 || t == 25 || t == 30 || t == 31) chk("gap_an", 32'(an_n), 32'hF);
            if (t == 26 || t == 29) begin
                chk("d0_an", 32'(an_n), 32'hE);
                chk("d0_seg", 32'(seg_n), 32'b1001100);
                chk("d0_dp", 32'(dp_n), 32'h0);
            end
            if (t == 32 || t == 35) begin
                chk("d1_an", 32'(an_n), 32'hD);
                chk("d1_seg", 32'(seg_n), 32'b0000110);
                chk("d1_dp", 32'(dp_n), 32'h1);
            end
        end

        // Load on the boundary, then a mid-frame load that must wait a frame.
        do_reset();
        while (t < 51) begin
            if (t == 23) begin load = 1'b1; digits = 16'hABCD; blank = 4'b0000; dp = 4'b0000; end
            if (t == 29) begin load = 1'b1; digits = 16'h0000; blank = 4'b0000; dp = 4'b0000; end
            cycle();
            load = 1'b0;
            if (t == 24) chk("bnd_fs", 32'(frame_start), 32'h1);
            if (t == 26) chk("bnd_seg_D", 32'(seg_n), 32'b1000010);
            if (t == 32) chk("hold_seg_C", 32'(seg_n), 32'b0110001);
            if (t == 50) chk("new_seg_0", 32'(seg_n), 32'b0000001);
        end

        // Blank mask on digit 2.
        do_reset();
        while (t < 46) begin
            if (t == 4) begin load = 1'b1; digits = 16'h1234; blank = 4'b0100; dp = 4'b0000; end
            cycle();
            load = 1'b0;
            if (t >= 38 && t <= 41) chk("blank_an", 32'(an_n), 32'hF);
            if (t == 44) begin
                chk("d3_an", 32'(an_n), 32'h7);
                chk("d3_seg", 32'(seg_n), 32'b1001111);
            end
        end

        // Mid-frame reset while digit 0 is lit.
        do_reset();
        while (t < 27) begin
            if (t == 4) begin load = 1'b1; digits = 16'h1234; blank = 4'b0000; dp = 4'b1111; end
            cycle();
            load = 1'b0;
        end
        chk("pre_rst_lit", 32'(an_n), 32'hE);
        do_reset();
        chk("mid_rst_an", 32'(an_n), 32'hF);
        chk("mid_rst_dp", 32'(dp_n), 32'h1);
        while (t < 30) begin
            cycle();
            if (t == 26) chk("post_rst_dark", 32'(an_n), 32'hF);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 5) == 0);
            digits = 16'($urandom);
            blank  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            dp     = 4'($urandom);
            cycle();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
